// File: rtl/lzc_pipe.sv
// Pipelined leading/trailing zero/one counter with valid/ready flow control.
// Slot 0 captures the raw operand; slots 1..STAGES run the halving tree.
module lzc_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_mode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(WIDTH):0] out_count,
  output logic                   out_zero,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int LV = $clog2(WIDTH);
  localparam int CW = LV + 1;
  localparam int NS = STAGES + 1;

  // Tree level lvl is evaluated in front of register slot slotOf(lvl).
  function automatic int unsigned slotOf(input int unsigned lvl);
    return (lvl * STAGES) / LV + 1;
  endfunction

  logic             vQ   [NS];
  logic [WIDTH-1:0] xQ   [NS];
  logic [LV-1:0]    cQ   [NS];
  logic [TAG_W-1:0] tQ   [NS];
  logic [1:0]       modeQ;
  logic [NS:0]      rdy;
  logic [WIDTH-1:0] prepX;

  assign rdy[NS]  = out_ready;
  assign in_ready = rdy[0] && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modeQ <= '0;
    end else if (in_ready && in_valid) begin
      modeQ <= in_mode;
    end
  end

  // Reduce every mode to a leading-zero count: invert for ones, reverse for trailing.
  always_comb begin : prep
    logic [WIDTH-1:0] inv;
    inv   = modeQ[0] ? ~xQ[0] : xQ[0];
    prepX = inv;
    if (modeQ[1]) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        prepX[i] = inv[WIDTH-1-i];
      end
    end
  end

  for (genvar k = 0; k < NS; k++) begin : slot
    logic             vIn;
    logic [WIDTH-1:0] xIn;
    logic [WIDTH-1:0] xNext;
    logic [LV-1:0]    cIn;
    logic [LV-1:0]    cNext;
    logic [TAG_W-1:0] tIn;

    if (k == 0) begin : head
      assign vIn = in_valid;
      assign xIn = in_data;
      assign cIn = '0;
      assign tIn = in_tag;
    end else begin : body
      assign vIn = vQ[k-1];
      assign xIn = (k == 1) ? prepX : xQ[k-1];
      assign cIn = cQ[k-1];
      assign tIn = tQ[k-1];
    end

    assign rdy[k] = !vQ[k] || rdy[k+1];

    // Each level tests the upper half of the remaining window; an empty half
    // contributes its size to the count and is shifted out.
    always_comb begin
      logic [WIDTH-1:0] mask;
      xNext = xIn;
      cNext = cIn;
      mask  = '0;
      for (int unsigned l = 0; l < LV; l++) begin
        if (slotOf(l) == k) begin
          mask = ~({WIDTH{1'b1}} >> (WIDTH >> (l + 1)));
          if ((xNext & mask) == '0) begin
            cNext[LV-1-l] = 1'b1;
            xNext         = xNext << (WIDTH >> (l + 1));
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vQ[k] <= 1'b0;
        xQ[k] <= '1;
        cQ[k] <= '0;
        tQ[k] <= '0;
      end else if (flush) begin
        vQ[k] <= 1'b0;
      end else if (rdy[k]) begin
        vQ[k] <= vIn;
        if (vIn) begin
          xQ[k] <= xNext;
          cQ[k] <= cNext;
          tQ[k] <= tIn;
        end
      end
    end
  end

  // After the full tree the MSB is set exactly when a terminating bit exists;
  // the all-ones reset value of xQ makes the idle outputs read count=0, zero=0.
  assign out_valid = vQ[NS-1];
  assign out_zero  = !xQ[NS-1][WIDTH-1];
  assign out_count = out_zero ? CW'(WIDTH) : {1'b0, cQ[NS-1]};
  assign out_tag   = tQ[NS-1];

endmodule

// File: tb/tb_lzc_pipe.sv
// Scoreboard bench for lzc_pipe: directed corner cases, latency, stall, flush,
// reset and randomized traffic checked against a bit-walking reference model.
module tb_lzc_pipe;

  localparam int W  = 64;
  localparam int S  = 2;
  localparam int TW = 4;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t        sbq[$];
  int unsigned nChecks = 0;
  int unsigned nFails  = 0;
  int          readyMode = 0;

  always #5 clk = ~clk;

  lzc_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .out_zero (out_zero),
    .out_tag  (out_tag)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Walk from the starting end counting bits equal to the target value.
  function automatic exp_t model(input logic [W-1:0] d, input logic [1:0] m, input logic [TW-1:0] t);
    exp_t        e;
    int unsigned n   = 0;
    bit          run = 1'b1;
    for (int i = 0; i < W; i++) begin
      int idx;
      idx = m[1] ? i : W - 1 - i;
      if (run && d[idx] == m[0]) n++;
      else run = 1'b0;
    end
    e.cnt  = CW'(n);
    e.zero = (n == W);
    e.tag  = t;
    return e;
  endfunction

  function automatic logic [W-1:0] randData();
    logic [W-1:0] r;
    logic [W-1:0] one;
    int unsigned  sh;
    r = '0;
    for (int i = 0; i < (W + 31) / 32; i++) r = (r << 32) | W'($urandom);
    sh  = $urandom_range(0, W - 1);
    one = W'(1) << sh;
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return one;
      3:       return ~one;
      4:       return r >> sh;
      5:       return r << sh;
      default: return r;
    endcase
  endfunction

  // Out-ready driver: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: pops on every handshake and checks hold stability on stalls.
  initial begin
    bit            holdPending = 1'b0;
    logic [CW-1:0] hCnt;
    logic          hZero;
    logic [TW-1:0] hTag;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        sbq.delete();
        holdPending = 1'b0;
      end else begin
        if (holdPending) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_count", 64'(out_count), 64'(hCnt));
          chk("hold_zero",  64'(out_zero),  64'(hZero));
          chk("hold_tag",   64'(out_tag),   64'(hTag));
        end
        holdPending = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (sbq.size() == 0) begin
              nChecks++;
              nFails++;
              $display("FAIL unexpected_output: out_valid=1 tag=%0d count=%0d, required no output",
                       out_tag, out_count);
            end else begin
              e = sbq.pop_front();
              chk("result_tag",   64'(out_tag),   64'(e.tag));
              chk("result_count", 64'(out_count), 64'(e.cnt));
              chk("result_zero",  64'(out_zero),  64'(e.zero));
            end
          end else begin
            holdPending = 1'b1;
            hCnt  = out_count;
            hZero = out_zero;
            hTag  = out_tag;
          end
        end
      end
    end
  end

  task automatic sendOp(input logic [W-1:0] d, input logic [1:0] m, input exp_t e);
    bit          acc    = 1'b0;
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = e.tag;
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!acc) begin
        waited++;
        if (waited > 500) begin
          nChecks++;
          nFails++;
          $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", waited);
          break;
        end
      end
    end
    // Scrambling mode/data after acceptance must not affect the result.
    in_valid = 1'b0;
    in_mode  = 2'($urandom_range(0, 3));
    in_data  = randData();
  endtask

  task automatic sendRand(input logic [TW-1:0] t);
    logic [W-1:0] d;
    logic [1:0]   m;
    d = randData();
    m = 2'($urandom_range(0, 3));
    sendOp(d, m, model(d, m, t));
  endtask

  // Single op into an empty, always-ready pipe: out_valid must rise S edges after acceptance.
  task automatic runLat(input logic [W-1:0] d, input logic [1:0] m, input exp_t e);
    sendOp(d, m, e);
    for (int c = 1; c <= S + 1; c++) begin
      @(negedge clk);
      chk("latency_valid", 64'(out_valid), 64'(c == S + 1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    readyMode = 0;
    for (int i = 0; i < 500 && sbq.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sbq.size()), 64'(0));
    chk("drain_no_valid", 64'(out_valid), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] dT [8];
    logic [1:0]   mT [8];
    logic [CW-1:0] cT [8];
    logic         zT [8];

    dT[0] = 64'h0000_0001_0000_0000; mT[0] = 2'b00; cT[0] = 31; zT[0] = 1'b0;
    dT[1] = 64'h0000_0001_0000_0000; mT[1] = 2'b10; cT[1] = 32; zT[1] = 1'b0;
    dT[2] = 64'h0000_0001_0000_0000; mT[2] = 2'b01; cT[2] = 0;  zT[2] = 1'b0;
    dT[3] = 64'h0000_0001_0000_0000; mT[3] = 2'b11; cT[3] = 0;  zT[3] = 1'b0;
    dT[4] = '0;                      mT[4] = 2'b00; cT[4] = 64; zT[4] = 1'b1;
    dT[5] = '1;                      mT[5] = 2'b01; cT[5] = 64; zT[5] = 1'b1;
    dT[6] = '1;                      mT[6] = 2'b00; cT[6] = 0;  zT[6] = 1'b0;
    dT[7] = 64'h8000_0000_0000_0000; mT[7] = 2'b00; cT[7] = 0;  zT[7] = 1'b0;

    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = '0;
    in_tag   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready",  64'(in_ready),  64'(1));
    chk("reset_count",     64'(out_count), 64'(0));
    chk("reset_zero",      64'(out_zero),  64'(0));
    chk("reset_tag",       64'(out_tag),   64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_valid", 64'(out_valid), 64'(0));
    end
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) runLat(dT[i], mT[i], '{cT[i], zT[i], TW'(i)});

    readyMode = 1;
    for (int i = 0; i < 16; i++) sendRand(TW'(i));
    drain();

    readyMode = 2;
    @(posedge clk);
    #1;
    sendRand(TW'(10));
    sendRand(TW'(11));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = randData();
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    readyMode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_no_valid", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    runLat(64'h1, 2'b00, '{CW'(63), 1'b0, TW'(5)});

    readyMode = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      sendRand(TW'(i));
    end
    drain();

    readyMode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) sendRand(TW'(i + 7));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'(0));
    chk("midreset_in_ready",  64'(in_ready),  64'(1));
    chk("midreset_count",     64'(out_count), 64'(0));
    chk("midreset_zero",      64'(out_zero),  64'(0));
    chk("midreset_tag",       64'(out_tag),   64'(0));
    sbq.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    readyMode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postreset_no_valid", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    runLat(64'h0000_0000_0000_0100, 2'b10, '{CW'(8), 1'b0, TW'(3)});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
